pc_sequencer: RTL

//  Owns the program counter register and sequences its update each cycle: reset, sequential +4, branch, jump, stall, halt/resume.

---
 rtl/pc_sequencer_pkg.sv | 28 ++
 rtl/pc_sequencer_next_mux.sv | 52 +++++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: FSM state encoding, PC step size and small
// arithmetic helpers used by both the sequencer and its next-PC mux.
package pc_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2,
      ST_HALT  = 2'd3
   } pc_state_e;

   localparam logic [31:0] PC_STEP   = 32'd4;
   localparam logic [31:0] COUNT_ONE = 32'd1;

   // PC arithmetic is modulo 2^32, so 32'hFFFF_FFFC steps to 32'h0.
   function automatic logic [31:0] pc_step(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

   function automatic logic [31:0] count_inc(input logic [31:0] cnt);
      return cnt + COUNT_ONE;
   endfunction

   function automatic logic is_word_aligned(input logic [31:0] addr);
      return (addr[1:0] == 2'b00);
   endfunction

endpackage

// File: rtl/pc_sequencer_next_mux.sv
// Combinational next-PC select: jump over branch over PC+4, with target alignment handling.
// PC_ALIGN_CHECK_EN: misaligned target selects TRAP_PC and raises fault_o; otherwise low bits are cleared.
module pc_sequencer_next_mux
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] TRAP_PC = 32'h0000_0080
) (
   input  logic [31:0] pc_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   output logic [31:0] pc_plus4_o,
   output logic [31:0] next_pc_o,
   output logic        fault_o
);

   logic        redirect;
   logic [31:0] target;

   assign pc_plus4_o = pc_step(pc_i);
   assign redirect   = jump_i | branch_taken_i;
   assign target     = jump_i ? jump_target_i : branch_target_i;

`ifdef PC_ALIGN_CHECK_EN
   always_comb begin
      next_pc_o = pc_plus4_o;
      fault_o   = 1'b0;
      if (redirect) begin
         if (is_word_aligned(target)) begin
            next_pc_o = target;
         end else begin
            next_pc_o = TRAP_PC;
            fault_o   = 1'b1;
         end
      end
   end
`else
   logic unused_trap_pc;
   assign unused_trap_pc = ^TRAP_PC;

   // Without the checker, a misaligned target silently loads its word-aligned address.
   always_comb begin
      next_pc_o = pc_plus4_o;
      fault_o   = 1'b0;
      if (redirect) begin
         next_pc_o = {target[31:2], 2'b00};
      end
   end
`endif

endmodule

// File: rtl/pc_sequencer.sv
// Program counter owner: IDLE/RUN/STALL/HALT sequencing plus cycle/retired counters; redirects show one edge later.
// Stall holds the PC and drops any redirect; PC_ALIGN_CHECK_EN enables trapping of misaligned targets.
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        stall_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   input  logic        halt_i,
   input  logic        resume_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc_plus4_o,
   output logic        pc_valid_o,
   output logic        halted_o,
   output logic [31:0] cycle_count_o,
   output logic [31:0] retired_count_o,
   output logic        align_fault_o
);

   pc_state_e   state_q;
   logic [31:0] pc_q;
   logic [31:0] cycle_q;
   logic [31:0] retired_q;
   logic        align_fault_q;
   logic        pc_valid_q;
   logic        halted_q;

   logic [31:0] next_pc;
   logic [31:0] pc_plus4;
   logic        mux_fault;
   logic [31:0] cycle_d;
   logic [31:0] retired_d;

   pc_sequencer_next_mux #(
      .TRAP_PC (TRAP_PC)
   ) u_next_mux (
      .pc_i            (pc_q),
      .jump_i          (jump_i),
      .jump_target_i   (jump_target_i),
      .branch_taken_i  (branch_taken_i),
      .branch_target_i (branch_target_i),
      .pc_plus4_o      (pc_plus4),
      .next_pc_o       (next_pc),
      .fault_o         (mux_fault)
   );

   assign cycle_d   = count_inc(cycle_q);
   assign retired_d = count_inc(retired_q);

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q       <= ST_IDLE;
         pc_q          <= RESET_PC;
         cycle_q       <= '0;
         retired_q     <= '0;
         align_fault_q <= 1'b0;
         pc_valid_q    <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         align_fault_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               state_q    <= ST_RUN;
               pc_valid_q <= 1'b1;
            end
            ST_RUN: begin
               cycle_q <= cycle_d;
               if (halt_i) begin
                  state_q    <= ST_HALT;
                  pc_valid_q <= 1'b0;
                  halted_q   <= 1'b1;
               end else if (stall_i) begin
                  // A redirect presented alongside a stall is dropped; the requester re-asserts it.
                  state_q    <= ST_STALL;
                  pc_valid_q <= 1'b0;
               end else begin
                  pc_q          <= next_pc;
                  retired_q     <= retired_d;
                  align_fault_q <= mux_fault;
               end
            end
            ST_STALL: begin
               cycle_q <= cycle_d;
               if (!stall_i) begin
                  state_q    <= ST_RUN;
                  pc_valid_q <= 1'b1;
               end
            end
            ST_HALT: begin
               if (resume_i) begin
                  state_q    <= ST_RUN;
                  pc_q       <= pc_plus4;
                  retired_q  <= retired_d;
                  pc_valid_q <= 1'b1;
                  halted_q   <= 1'b0;
               end
            end
            default: begin
               state_q    <= ST_IDLE;
               pc_valid_q <= 1'b0;
               halted_q   <= 1'b0;
            end
         endcase
      end
   end

   assign pc_o            = pc_q;
   assign pc_plus4_o      = pc_plus4;
   assign pc_valid_o      = pc_valid_q;
   assign halted_o        = halted_q;
   assign cycle_count_o   = cycle_q;
   assign retired_count_o = retired_q;
   assign align_fault_o   = align_fault_q;

endmodule
